// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared types, defaults and helpers for the bit-serial MAC sequencer
//
// Purpose: state enum for the sequencer FSM, default widths, and the
//          lowest-set-bit priority encoder used by zero-bit skipping
//          (BSA_ZERO_SKIP_EN).
// Ports:   none (package)
package bsa_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_ACC_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } mac_state_t;

  // Index of the lowest set bit; 0 when no bit is set (callers gate on v != 0).
  function automatic logic [4:0] lsb_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bit_sparse_mac_ctrl_if.sv
// rtl/bit_sparse_mac_ctrl_if.sv - input-pair and result handshake bundle
//
// Purpose: groups the (act, wgt, last) input handshake, the result handshake
//          and the busy flag.
// Ports:   in_valid/in_ready/in_act/in_wgt/in_last - pair handshake
//          out_valid/out_ready/out_acc              - result handshake
//          busy                                     - sequencer not idle
//          master: producer/consumer side; slave: the sequencer.
interface bit_sparse_mac_ctrl_if
  import bsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_act;
  logic [WIDTH-1:0]     in_wgt;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 busy;

  modport master (
    output in_valid, in_act, in_wgt, in_last, out_ready,
    input  in_ready, out_valid, out_acc, busy
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last, out_ready,
    output in_ready, out_valid, out_acc, busy
  );
endinterface

// File: rtl/NBitAdder.sv
// rtl/NBitAdder.sv - unsigned N-bit adder, carry-out discarded
//
// Purpose: shared accumulator adder; sum wraps modulo 2^bitsize.
// Ports:   input1, input2 - addends (bitsize bits)
//          answer         - input1 + input2 (bitsize bits)
module NBitAdder #(
  parameter int bitsize = 20
) (
  input  logic [bitsize-1:0] input1,
  input  logic [bitsize-1:0] input2,
  output logic [bitsize-1:0] answer
);

  assign answer = input1 + input2;

endmodule

// File: rtl/bit_sparse_mac_ctrl.sv
// rtl/bit_sparse_mac_ctrl.sv - bit-serial multiply-accumulate sequencer
//
// Purpose: accepts (act, wgt, last) pairs, adds act shifted by each set weight
//          bit into an accumulator through one shared NBitAdder, and presents
//          the sum once the pair marked last has been consumed.
//          Build option BSA_ZERO_SKIP_EN: walk only set weight bits
//          (max(1, popcount) SCAN cycles); otherwise WIDTH SCAN cycles.
// Ports:   clk   - clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - bit_sparse_mac_ctrl_if.slave (pair/result handshakes, busy)
module bit_sparse_mac_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_sparse_mac_ctrl_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mac_state_t           state_q, state_d;
  logic [WIDTH-1:0]     act_q, act_d;
  logic [WIDTH-1:0]     wgt_q, wgt_d;
  logic                 last_q, last_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [IDX_W-1:0]     shift_amt;
  logic                 add_en;
  logic                 scan_done;
  logic [WIDTH-1:0]     wgt_next;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;

`ifdef BSA_ZERO_SKIP_EN
  // Remaining weight with its lowest set bit cleared; SCAN ends when this
  // reaches zero, which also covers a zero weight in a single cycle.
  always_comb begin
    shift_amt = IDX_W'(lsb_index(32'(wgt_q)));
    add_en    = (wgt_q != '0);
    wgt_next  = wgt_q & (wgt_q - 1'b1);
    scan_done = (wgt_next == '0);
  end
`else
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

  always_comb begin
    shift_amt = bit_idx_q;
    add_en    = wgt_q[bit_idx_q];
    wgt_next  = wgt_q;
    scan_done = (bit_idx_q == IDX_W'(WIDTH - 1));
  end

  always_comb begin
    bit_idx_d = bit_idx_q;
    if (state_q == IDLE) begin
      bit_idx_d = '0;
    end else if (state_q == SCAN && !scan_done) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q <= '0;
    end else begin
      bit_idx_q <= bit_idx_d;
    end
  end
`endif

  // Unused bits contribute zero rather than skipping the adder, so the
  // accumulator path is the same in every SCAN cycle.
  always_comb begin
    addend = '0;
    if (add_en) addend = ACC_WIDTH'(act_q) << shift_amt;
  end

  NBitAdder #(
    .bitsize (ACC_WIDTH)
  ) u_adder (
    .input1 (acc_q),
    .input2 (addend),
    .answer (sum)
  );

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    wgt_d       = wgt_q;
    last_d      = last_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          act_d      = bus.in_act;
          wgt_d      = bus.in_wgt;
          last_d     = bus.in_last;
          state_d    = SCAN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SCAN: begin
        acc_d = sum;
        wgt_d = wgt_next;
        if (scan_done) begin
          if (last_q) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end else begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          acc_d       = '0;
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q       <= '0;
      wgt_q       <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // acc only changes in SCAN and on the output handshake, so it is stable in OUT.
  assign bus.out_acc   = acc_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bit_sparse_mac_ctrl.sv
// tb/tb_bit_sparse_mac_ctrl.sv - directed self-checking bench for bit_sparse_mac_ctrl
module tb_bit_sparse_mac_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_sparse_mac_ctrl_if #(.WIDTH(8), .ACC_WIDTH(20)) bus_a ();
  bit_sparse_mac_ctrl_if #(.WIDTH(8), .ACC_WIDTH(16)) bus_b ();

  bit_sparse_mac_ctrl #(.WIDTH(8), .ACC_WIDTH(20)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  bit_sparse_mac_ctrl #(.WIDTH(8), .ACC_WIDTH(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_act    = bus_a.in_act;
  assign bus_b.in_wgt    = bus_a.in_wgt;
  assign bus_b.in_last   = bus_a.in_last;
  assign bus_b.out_ready = bus_a.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_k(input logic [7:0] wgt);
`ifdef BSA_ZERO_SKIP_EN
    int c;
    c = $countones(wgt);
    return (c == 0) ? 1 : c;
`else
    return 8;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, then count SCAN cycles after the accept edge.
  task automatic send(input string tag, input logic [7:0] act, input logic [7:0] wgt,
                      input logic last);
    int k;
    int wait_cnt;
    wait_cnt = 0;
    while (!bus_a.in_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check({tag, "_ready"}, 32'(bus_a.in_ready), 32'd1);
    bus_a.in_act   = act;
    bus_a.in_wgt   = wgt;
    bus_a.in_last  = last;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    k = 0;
    while (bus_a.busy && !bus_a.out_valid && k < 40) begin
      k++;
      tick();
    end
    check({tag, "_scan_cycles"}, 32'(k), 32'(exp_k(wgt)));
    check({tag, "_out_valid"}, 32'(bus_a.out_valid), 32'(last));
    check({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'(!last));
  endtask

  task automatic take(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
    check({tag, "_acc20"}, 32'(bus_a.out_acc), exp_a);
    check({tag, "_acc16"}, 32'(bus_b.out_acc), exp_b);
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, "_ready_rise"}, 32'(bus_a.in_ready), 32'd1);
    check({tag, "_acc_clr"}, 32'(bus_a.out_acc), 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_act    = '0;
    bus_a.in_wgt    = '0;
    bus_a.in_last   = 1'b0;
    bus_a.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_out_acc", 32'(bus_a.out_acc), 32'd0);
    rst_n = 1'b1;
    tick();

    // 5 * 6 = 30
    send("t1", 8'd5, 8'b0000_0110, 1'b1);
    take("t1", 32'd30, 32'd30);

    // zero weight
    send("t2", 8'd200, 8'd0, 1'b1);
    take("t2", 32'd0, 32'd0);

    // 3*4 + 7*2 = 26, no result between the pairs
    send("t3a", 8'd3, 8'd4, 1'b0);
    check("t3_no_valid_between", 32'(bus_a.out_valid), 32'd0);
    check("t3_partial", 32'(bus_a.out_acc), 32'd12);
    send("t3b", 8'd7, 8'd2, 1'b1);
    take("t3", 32'd26, 32'd26);

    // 2 * 65025 = 130050; 130050 mod 65536 = 64514 on the 16-bit accumulator
    send("t4a", 8'd255, 8'd255, 1'b0);
    send("t4b", 8'd255, 8'd255, 1'b1);
    take("t4", 32'd130050, 32'd64514);

    // 1*0x81 = 129, stalled 5 cycles in OUT
    send("t5", 8'd1, 8'h81, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_stall_valid", 32'(bus_a.out_valid), 32'd1);
      check("t5_stall_acc", 32'(bus_a.out_acc), 32'd129);
      check("t5_stall_in_ready", 32'(bus_a.in_ready), 32'd0);
    end
    take("t5", 32'd129, 32'd129);

    // reset mid-SCAN of (9, 0xF0, last)
    bus_a.in_act   = 8'd9;
    bus_a.in_wgt   = 8'hF0;
    bus_a.in_last  = 1'b1;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    check("t6_in_scan", 32'(bus_a.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("t6_rst_busy", 32'(bus_a.busy), 32'd0);
    check("t6_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("t6_rst_out_acc", 32'(bus_a.out_acc), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send("t6", 8'd2, 8'd3, 1'b1);
    take("t6", 32'd6, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
